// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and beat-count helpers for the write-back vector sequencer
package wb_pkg;

  typedef enum logic [1:0] {
    OP_SCALAR = 2'b00,
    OP_VECTOR = 2'b01,
    OP_BCAST  = 2'b10,
    OP_RSVD   = 2'b11
  } optype_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_state_e;

  function automatic int wb_beat_count(input int v, input int p);
    return v / p;
  endfunction

  // Beat index needs at least one bit even when a vector fits in a single beat.
  function automatic int wb_beat_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/wb_lane_buffer.sv
// rtl/wb_lane_buffer.sv - V-lane capture register with P-lane indexed read for beat serialization
module wb_lane_buffer
  import wb_pkg::*;
#(
  parameter int V  = 20,
  parameter int L  = 8,
  parameter int P  = 4,
  parameter int BW = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                load_i,
  input  logic [V-1:0][L-1:0] vec_i,
  input  logic [BW-1:0]       beat_i,
  output logic [P-1:0][L-1:0] rd_o
);

  logic [V-1:0][L-1:0] buf_q;

  // Capture the whole vector when a burst starts; contents stay put until the next load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= vec_i;
    end
  end

  // Select the P lanes belonging to the requested beat.
  always_comb begin
    rd_o = '0;
    for (int p = 0; p < P; p++) begin
      rd_o[p] = buf_q[int'(beat_i) * P + p];
    end
  end

endmodule

// File: rtl/wb_vector_sequencer.sv
// rtl/wb_vector_sequencer.sv - MEM/WB consumer serializing vector writes into P-lane beats (WB_SCALAR_BYPASS_EN: scalar retire during bursts)
module wb_vector_sequencer
  import wb_pkg::*;
#(
  parameter int N  = 32,
  parameter int V  = 20,
  parameter int L  = 8,
  parameter int P  = 4,
  parameter int NB = wb_beat_count(V, P),
  parameter int BW = wb_beat_width(NB)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [4:0]          A3_i,
  input  logic [N-1:0]        Data_Mem_S_i,
  input  logic [N-1:0]        Data_Result_S_i,
  input  logic [V-1:0][L-1:0] Data_Mem_V_i,
  input  logic [V-1:0][L-1:0] Data_Result_V_i,
  input  logic [1:0]          OpType_i,
  input  logic                RegFile_WE_i,
  input  logic                WBSelect_i,
  output logic                stall_o,
  output logic                SRF_WE_o,
  output logic [4:0]          SRF_A3_o,
  output logic [N-1:0]        SRF_WD_o,
  output logic                VRF_WE_o,
  output logic [4:0]          VRF_A3_o,
  output logic [BW-1:0]       VRF_Beat_o,
  output logic [P-1:0][L-1:0] VRF_WD_o,
  output logic                busy_o
);

  wb_state_e           state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [4:0]          a3_q;
  logic                load;
  optype_e             op;
  logic [N-1:0]        sel_s;
  logic [V-1:0][L-1:0] sel_v;
  logic [V-1:0][L-1:0] vec_in;
  logic [P-1:0][L-1:0] buf_rd;

  assign op = optype_e'(OpType_i);

  // Source select; broadcast replicates the low lane of the selected scalar across every lane.
  always_comb begin
    sel_s  = WBSelect_i ? Data_Mem_S_i : Data_Result_S_i;
    sel_v  = WBSelect_i ? Data_Mem_V_i : Data_Result_V_i;
    vec_in = sel_v;
    if (op == OP_BCAST) begin
      for (int i = 0; i < V; i++) begin
        vec_in[i] = sel_s[L-1:0];
      end
    end
  end

  wb_lane_buffer #(
    .V  (V),
    .L  (L),
    .P  (P),
    .BW (BW)
  ) u_lane_buffer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load_i (load),
    .vec_i  (vec_in),
    .beat_i (beat_q),
    .rd_o   (buf_rd)
  );

  // Burst state, beat counter and captured destination register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      beat_q  <= '0;
      a3_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (load) begin
        a3_q <= A3_i;
      end
    end
  end

  // Next state and write-port drive; everything is forced low while reset is asserted.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    load       = 1'b0;
    stall_o    = 1'b0;
    busy_o     = 1'b0;
    SRF_WE_o   = 1'b0;
    SRF_A3_o   = '0;
    SRF_WD_o   = '0;
    VRF_WE_o   = 1'b0;
    VRF_A3_o   = '0;
    VRF_Beat_o = '0;
    VRF_WD_o   = '0;
    if (RST_N) begin
      case (state_q)
        IDLE: begin
          if (RegFile_WE_i) begin
            case (op)
              OP_SCALAR: begin
                SRF_WE_o = 1'b1;
                SRF_A3_o = A3_i;
                SRF_WD_o = sel_s;
              end
              OP_VECTOR, OP_BCAST: begin
                // Beat 0 goes straight from the inputs; the rest are replayed from the buffer.
                VRF_WE_o = 1'b1;
                VRF_A3_o = A3_i;
                VRF_WD_o = vec_in[P-1:0];
                if (NB > 1) begin
                  load    = 1'b1;
                  beat_d  = BW'(1);
                  state_d = BUSY;
                end
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          busy_o     = 1'b1;
          stall_o    = 1'b1;
          VRF_WE_o   = 1'b1;
          VRF_A3_o   = a3_q;
          VRF_Beat_o = beat_q;
          VRF_WD_o   = buf_rd;
          if (beat_q == BW'(NB - 1)) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
`ifdef WB_SCALAR_BYPASS_EN
          // Anything that does not need the vector port can retire alongside the beat.
          if (!RegFile_WE_i || op == OP_RSVD || op == OP_SCALAR) begin
            stall_o = 1'b0;
            if (RegFile_WE_i && op == OP_SCALAR) begin
              SRF_WE_o = 1'b1;
              SRF_A3_o = A3_i;
              SRF_WD_o = sel_s;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_vector_sequencer.sv
// tb/tb_wb_vector_sequencer.sv - scoreboard bench for wb_vector_sequencer
module tb_wb_vector_sequencer;

  localparam int N  = 32;
  localparam int V  = 20;
  localparam int L  = 8;
  localparam int P  = 4;
  localparam int NB = 5;
  localparam int BW = 3;

`ifdef WB_SCALAR_BYPASS_EN
  localparam int EXP_SCALAR_GAP = 1;
  localparam int EXP_STALL_BUBBLE = 0;
`else
  localparam int EXP_SCALAR_GAP = 5;
  localparam int EXP_STALL_BUBBLE = 4;
`endif

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [4:0]          A3_i;
  logic [N-1:0]        Data_Mem_S_i, Data_Result_S_i;
  logic [V-1:0][L-1:0] Data_Mem_V_i, Data_Result_V_i;
  logic [1:0]          OpType_i;
  logic                RegFile_WE_i, WBSelect_i;
  logic                stall_o, SRF_WE_o, VRF_WE_o, busy_o;
  logic [4:0]          SRF_A3_o, VRF_A3_o;
  logic [N-1:0]        SRF_WD_o;
  logic [BW-1:0]       VRF_Beat_o;
  logic [P-1:0][L-1:0] VRF_WD_o;

  wb_vector_sequencer #(.N(N), .V(V), .L(L), .P(P)) dut (
    .CLK(CLK), .RST_N(RST_N), .A3_i(A3_i),
    .Data_Mem_S_i(Data_Mem_S_i), .Data_Result_S_i(Data_Result_S_i),
    .Data_Mem_V_i(Data_Mem_V_i), .Data_Result_V_i(Data_Result_V_i),
    .OpType_i(OpType_i), .RegFile_WE_i(RegFile_WE_i), .WBSelect_i(WBSelect_i),
    .stall_o(stall_o), .SRF_WE_o(SRF_WE_o), .SRF_A3_o(SRF_A3_o), .SRF_WD_o(SRF_WD_o),
    .VRF_WE_o(VRF_WE_o), .VRF_A3_o(VRF_A3_o), .VRF_Beat_o(VRF_Beat_o),
    .VRF_WD_o(VRF_WD_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] a3; logic [N-1:0] d; } sexp_t;
  typedef struct { logic [4:0] a3; logic [BW-1:0] beat; logic [P*L-1:0] d; } vexp_t;

  sexp_t sq[$];
  vexp_t vq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int srf_cyc = 0, beat0_cyc = 0, vrf_first = 0, vrf_last = 0;
  int vrf_cnt = 0, busy_cnt = 0, stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: pops expectations as the write ports fire.
  always @(negedge CLK) begin
    if (SRF_WE_o) begin
      srf_cyc = cyc;
      if (sq.size() == 0) check("srf_unexpected", 1, 0);
      else begin
        sexp_t e;
        e = sq.pop_front();
        check("srf_a3", SRF_A3_o, e.a3);
        check("srf_wd", SRF_WD_o, e.d);
      end
    end
    if (VRF_WE_o) begin
      if (VRF_Beat_o == 0) beat0_cyc = cyc;
      if (vrf_cnt == 0) vrf_first = cyc;
      vrf_last = cyc;
      vrf_cnt++;
      if (vq.size() == 0) check("vrf_unexpected", 1, 0);
      else begin
        vexp_t e;
        e = vq.pop_front();
        check("vrf_a3", VRF_A3_o, e.a3);
        check("vrf_beat", VRF_Beat_o, e.beat);
        check("vrf_wd", VRF_WD_o, e.d);
      end
    end
    if (busy_o) busy_cnt++;
    if (stall_o) stall_cnt++;
  end

  task automatic exp_scalar(input logic [4:0] a3, input logic [N-1:0] d);
    sexp_t e;
    e.a3 = a3;
    e.d = d;
    sq.push_back(e);
  endtask

  task automatic exp_vector(input logic [4:0] a3, input logic [V-1:0][L-1:0] vec);
    for (int b = 0; b < NB; b++) begin
      vexp_t e;
      e.a3 = a3;
      e.beat = BW'(b);
      e.d = '0;
      for (int p = 0; p < P; p++) e.d[p*L +: L] = vec[b*P + p];
      vq.push_back(e);
    end
  endtask

  // Hold current inputs until the DUT consumes them; returns just after the consuming edge.
  task automatic issue();
    int n = 0;
    @(negedge CLK);
    while (stall_o && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 100) check("stall_timeout", 1, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  logic [V-1:0][L-1:0] vec_a, vec_b;

  initial begin
    RST_N = 1'b0;
    A3_i = 5'd0;
    Data_Mem_S_i = '0;
    Data_Result_S_i = '0;
    Data_Mem_V_i = '0;
    Data_Result_V_i = '0;
    OpType_i = 2'b00;
    RegFile_WE_i = 1'b1;
    WBSelect_i = 1'b1;
    Data_Mem_S_i = 32'hFFFF_FFFF;
    A3_i = 5'd31;

    // Reset forces outputs low even with a scalar write presented.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_srf_we", SRF_WE_o, 0);
    check("rst_srf_wd", SRF_WD_o, 0);
    check("rst_vrf_we", VRF_WE_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_busy", busy_o, 0);
    RegFile_WE_i = 1'b0;
    RST_N = 1'b1;
    idle(2);

    // Scalar from memory.
    OpType_i = 2'b00; WBSelect_i = 1'b1; A3_i = 5'd7;
    Data_Mem_S_i = 32'h1234_5678; Data_Result_S_i = 32'hDEAD_BEEF;
    RegFile_WE_i = 1'b1;
    exp_scalar(5'd7, 32'h1234_5678);
    #1;
    check("scalar_comb_we", SRF_WE_o, 1);
    check("scalar_stall", stall_o, 0);
    issue();
    RegFile_WE_i = 1'b0;
    idle(3);

    // Vector from result, lane i = i.
    for (int i = 0; i < V; i++) begin
      vec_a[i] = 8'(i);
      vec_b[i] = 8'hEE;
    end
    Data_Result_V_i = vec_a; Data_Mem_V_i = vec_b;
    OpType_i = 2'b01; WBSelect_i = 1'b0; A3_i = 5'd3;
    exp_vector(5'd3, vec_a);
    busy_cnt = 0; stall_cnt = 0;
    RegFile_WE_i = 1'b1;
    issue();
    RegFile_WE_i = 1'b0;
    idle(8);
    check("vec_busy_cycles", busy_cnt, 4);
    check("vec_stall_cycles", stall_cnt, EXP_STALL_BUBBLE);

    // Broadcast of result scalar low lane.
    for (int i = 0; i < V; i++) vec_a[i] = 8'hAB;
    OpType_i = 2'b10; WBSelect_i = 1'b0; A3_i = 5'd4;
    Data_Result_S_i = 32'h0000_00AB; Data_Mem_S_i = 32'h0000_00CD;
    exp_vector(5'd4, vec_a);
    RegFile_WE_i = 1'b1;
    issue();
    RegFile_WE_i = 1'b0;
    idle(8);

    // Vector followed immediately by scalar.
    for (int i = 0; i < V; i++) vec_a[i] = 8'(8'h40 + i);
    Data_Mem_V_i = vec_a;
    OpType_i = 2'b01; WBSelect_i = 1'b1; A3_i = 5'd5;
    exp_vector(5'd5, vec_a);
    RegFile_WE_i = 1'b1;
    issue();
    OpType_i = 2'b00; WBSelect_i = 1'b0; A3_i = 5'd9;
    Data_Result_S_i = 32'h55AA_00FF;
    exp_scalar(5'd9, 32'h55AA_00FF);
    issue();
    RegFile_WE_i = 1'b0;
    idle(8);
    check("scalar_after_vec_gap", srf_cyc - beat0_cyc, EXP_SCALAR_GAP);

    // Reset asserted during beat 2 aborts the burst.
    for (int i = 0; i < V; i++) vec_a[i] = 8'(8'h80 + i);
    Data_Result_V_i = vec_a;
    OpType_i = 2'b01; WBSelect_i = 1'b0; A3_i = 5'd6;
    exp_vector(5'd6, vec_a);
    RegFile_WE_i = 1'b1;
    issue();
    RegFile_WE_i = 1'b0;
    @(posedge CLK);
    #1;
    check("midburst_beat", VRF_Beat_o, 2);
    RST_N = 1'b0;
    #1;
    check("midburst_rst_vrf_we", VRF_WE_o, 0);
    check("midburst_rst_busy", busy_o, 0);
    check("midburst_rst_stall", stall_o, 0);
    check("midburst_rst_wd", VRF_WD_o, 0);
    vq.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    vrf_cnt = 0;
    idle(8);
    check("post_rst_no_beats", vrf_cnt, 0);
    check("post_rst_busy", busy_o, 0);

    // Back-to-back vectors to A3=1 then A3=2.
    for (int i = 0; i < V; i++) begin
      vec_a[i] = 8'(8'h10 + i);
      vec_b[i] = 8'(8'h30 + i);
    end
    OpType_i = 2'b01; WBSelect_i = 1'b0;
    vrf_cnt = 0;
    Data_Result_V_i = vec_a; A3_i = 5'd1;
    exp_vector(5'd1, vec_a);
    RegFile_WE_i = 1'b1;
    issue();
    Data_Result_V_i = vec_b; A3_i = 5'd2;
    exp_vector(5'd2, vec_b);
    issue();
    RegFile_WE_i = 1'b0;
    idle(10);
    check("b2b_beats", vrf_cnt, 10);
    check("b2b_span", vrf_last - vrf_first, 9);

    // Reserved op and bubble: consumed without any write.
    OpType_i = 2'b11; A3_i = 5'd12; RegFile_WE_i = 1'b1;
    #1;
    check("rsvd_srf_we", SRF_WE_o, 0);
    check("rsvd_vrf_we", VRF_WE_o, 0);
    issue();
    OpType_i = 2'b00; RegFile_WE_i = 1'b0;
    #1;
    check("bubble_srf_we", SRF_WE_o, 0);
    issue();
    idle(4);

    check("srf_queue_empty", sq.size(), 0);
    check("vrf_queue_empty", vq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_vector_sequencer.md
# wb_vector_sequencer

Write-back stage consumer for the MEM/WB pipeline register of the vector ASIP. Selects memory or ALU result, retires scalar writes in one cycle, and serializes V-lane vector writes onto a P-lane vector register file write port over V/P beats, holding the MEM/WB register via a stall output while a burst is in flight.

## Interface
- N, 32, scalar data width
- V, 20, vector lanes
- L, 8, lane width
- P, 4, lanes written per beat; V % P == 0 required; NB = V/P beats
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- A3_i  in  5  destination register
- Data_Mem_S_i, Data_Result_S_i  in  N  scalar memory / ALU data
- Data_Mem_V_i, Data_Result_V_i  in  [V-1:0][L-1:0]  vector memory / ALU data
- OpType_i  in  2  00 scalar, 01 vector, 10 broadcast, 11 reserved
- RegFile_WE_i  in  1  write request; 0 = bubble
- WBSelect_i  in  1  1 = memory data, 0 = result data
- stall_o  out  1  drives MEM/WB enable_i low; input consumed in a cycle iff stall_o == 0
- SRF_WE_o, SRF_A3_o (5), SRF_WD_o (N)  out  scalar RF write port
- VRF_WE_o, VRF_A3_o (5)  out  vector RF write enable/address
- VRF_Beat_o  out  $clog2(NB)  beat index; lanes written = [Beat*P +: P]
- VRF_WD_o  out  [P-1:0][L-1:0]  beat data
- busy_o  out  1  burst in flight (state BUSY)

## Operation
- States: IDLE, BUSY. Counter beat_q (0..NB-1), buffer buf_q [V-1:0][L-1:0], address a3_q.
- Source select: WBSelect_i ? Mem : Result. Broadcast lane value = selected scalar [L-1:0] replicated to all V lanes.
- IDLE, input consumed (stall_o=0):
  - WE=0 or OpType 11: no write.
  - OpType 00: SRF_WE_o=1, SRF_A3_o=A3_i, SRF_WD_o=selected scalar.
  - OpType 01/10: VRF_WE_o=1, beat 0 driven combinationally from input; full vector into buf_q, A3_i into a3_q, beat_q<=1, go BUSY. If NB==1 stay IDLE.
- BUSY: VRF_WE_o=1, VRF_A3_o=a3_q, VRF_Beat_o=beat_q, VRF_WD_o=buf_q[beat_q*P +: P]; beat_q increments; after beat NB-1 go IDLE.
- BUSY, stall_o=1 (macro off): held MEM/WB instruction ignored, processed in first IDLE cycle.
- Scalar write and vector beat may occur same cycle (separate ports).

## Timing
- Scalar write: 0-cycle latency, combinational from inputs; RF commits at next edge.
- Vector write: NB consecutive beats, beat 0 in consumption cycle; stall_o high for NB-1 cycles.
- Back-to-back vector writes: second starts the cycle after the last beat of the first; no idle gap.
- Reset: while RST_N low, state IDLE, beat_q=0, buf_q=0, a3_q=0; all WE outputs, stall_o, busy_o and data outputs forced 0. Reset mid-burst aborts; remaining beats are lost.
- Bubble or reserved op in IDLE consumed in one cycle, no write.

## Configuration
- WB_SCALAR_BYPASS_EN defined: in BUSY, if held input is bubble, reserved or OpType 00, stall_o=0 and the scalar write (if any) retires that cycle alongside the vector beat; held vector/broadcast op keeps stall_o=1.
- Undefined: stall_o = busy_o; all held inputs wait for IDLE.

## Structure
- Package wb_pkg: optype_e enum (OP_SCALAR, OP_VECTOR, OP_BCAST, OP_RSVD), wb_state_e (IDLE, BUSY), beat-count function of V and P.
- One sub-module natural: wb_lane_buffer (V-lane load, P-lane indexed read).

## Test plan
- Reset asserted mid-burst at beat 2 -> WE outputs 0 immediately; after release state IDLE, beat_q=0, no further beats.
- Scalar, WBSelect=1, Data_Mem_S=0x12345678, A3=7 -> SRF_WE=1, A3=7, WD=0x12345678 same cycle; stall_o=0.
- Vector, WBSelect=0, lane i = i, A3=3 (V=20,P=4) -> 5 beats, Beat 0..4, WD lanes {4k+3..4k}; stall_o high 4 cycles.
- Broadcast, Data_Result_S=0xAB -> 5 beats, every lane 0xAB.
- Vector followed by scalar, macro off -> scalar SRF write in cycle 5; macro on -> scalar write in cycle 1, stall_o low that cycle.
- Back-to-back vector A3=1 then A3=2 -> 10 consecutive beats, address switches at beat 5; reserved op -> no writes.
